mem_stage: RTL and testbench

Memory-access stage controller between the execute stage and writeback. It takes the execute-stage ALU result as the effective address and the forwarded rt value as store data, and issues at most one transaction on the SRAM-like data bus (split address/data handshake). It aligns and extends load data, replicates store data across byte lanes, flags address errors for CP0, and stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store on a split addr/data bus, aligns load data, flags address errors.
// Latency: 0 stall cycles when addr_ok and data_ok arrive with the request; +1 per cycle either is missing.
// Backpressure: mem_stall holds F/D/E/M while a transaction is owned; a request, once raised, holds until addr_ok.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_memread,
  input  logic        m_memwrite,
  input  logic [1:0]  m_size,
  input  logic        m_load_sign,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_flush,
  input  logic        pipe_adv,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] load_data,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        mem_stall
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] held_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic        sign_q;

  logic        misaligned, acc, in_idle, in_flight;
  logic        complete, drop, load_hit, both_ok;
  logic [31:0] wdata_rep, shifted, extracted;
  logic        cur_sign;

  // Alignment check, request qualification and store lane replication from the M-stage inputs.
  always_comb begin
    misaligned = ((m_size == 2'b01) && m_addr[0]) || (m_size[1] && (m_addr[1:0] != 2'b00));
    acc        = (m_memread || m_memwrite) && !misaligned && !m_flush;
    case (m_size)
      2'b00:   wdata_rep = {4{m_wdata[7:0]}};
      2'b01:   wdata_rep = {2{m_wdata[15:0]}};
      default: wdata_rep = m_wdata;
    endcase
  end

  assign adel     = m_memread && misaligned;
  assign ades     = m_memwrite && misaligned;
  assign badvaddr = m_addr;

  assign in_idle   = (state_q == S_IDLE);
  assign in_flight = (state_q == S_REQ) || (state_q == S_RESP);
  assign both_ok   = data_addr_ok && data_data_ok;

  // In IDLE the bus sees the live M inputs; once issued, the latched copy keeps it stable.
  assign data_wr    = in_idle ? m_memwrite  : wr_q;
  assign data_size  = in_idle ? m_size      : size_q;
  assign data_addr  = in_idle ? m_addr      : addr_q;
  assign data_wdata = in_idle ? wdata_rep   : wdata_q;
  assign cur_sign   = in_idle ? m_load_sign : sign_q;

  // Completion, discard and stall decode for the owned transaction.
  always_comb begin
    complete  = 1'b0;
    data_req  = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        complete  = acc && both_ok;
        data_req  = acc;
        mem_stall = acc && !both_ok;
      end
      S_REQ: begin
        complete  = both_ok;
        data_req  = 1'b1;
        mem_stall = !both_ok;
      end
      S_RESP: begin
        complete  = data_data_ok;
        mem_stall = !data_data_ok;
      end
      default: ;
    endcase
    // A flush arriving on the completion cycle drops the data just like an earlier one.
    drop     = in_flight && (discard_q || m_flush);
    load_hit = complete && !data_wr && !drop;
  end

  // Load alignment: shift the addressed lane down, then extend by the access's sign flag.
  always_comb begin
    shifted = data_rdata >> {data_addr[1:0], 3'b000};
    case (data_size)
      2'b00:   extracted = {{24{cur_sign && shifted[7]}}, shifted[7:0]};
      2'b01:   extracted = {{16{cur_sign && shifted[15]}}, shifted[15:0]};
      default: extracted = shifted;
    endcase
  end

  assign load_data = load_hit ? extracted : held_q;

  // Next-state and discard-flag decode.
  always_comb begin
    state_d   = state_q;
    discard_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (both_ok)           state_d = pipe_adv ? S_IDLE : S_DONE;
          else if (data_addr_ok) state_d = S_RESP;
          else                   state_d = S_REQ;
        end
      end
      S_REQ: begin
        discard_d = discard_q || m_flush;
        if (both_ok) begin
          state_d   = (pipe_adv || drop) ? S_IDLE : S_DONE;
          discard_d = 1'b0;
        end else if (data_addr_ok) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        discard_d = discard_q || m_flush;
        if (data_data_ok) begin
          state_d   = (pipe_adv || drop) ? S_IDLE : S_DONE;
          discard_d = 1'b0;
        end
      end
      default: begin
        if (pipe_adv || m_flush) state_d = S_IDLE;
      end
    endcase
  end

  // State, discard flag, held load result and issue-time attribute latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      held_q    <= 32'h0;
      addr_q    <= 32'h0;
      size_q    <= 2'b00;
      wr_q      <= 1'b0;
      wdata_q   <= 32'h0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (load_hit) held_q <= extracted;
      if (in_idle && acc) begin
        addr_q  <= m_addr;
        size_q  <= m_size;
        wr_q    <= m_memwrite;
        wdata_q <= wdata_rep;
        sign_q  <= m_load_sign;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misalignment, flush discard and reset during a transaction.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after the edge.
// Each step is a hand-computed vector; results are tallied into a single summary line.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_memread, m_memwrite, m_load_sign, m_flush, pipe_adv;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] load_data;
  logic        adel, ades;
  logic [31:0] badvaddr;
  logic        mem_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .m_memread(m_memread), .m_memwrite(m_memwrite), .m_size(m_size),
    .m_load_sign(m_load_sign), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_flush(m_flush), .pipe_adv(pipe_adv),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .load_data(load_data), .adel(adel), .ades(ades), .badvaddr(badvaddr),
    .mem_stall(mem_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    m_memread = 0; m_memwrite = 0; m_size = 2'b10; m_load_sign = 0;
    m_addr = 32'h0; m_wdata = 32'h0; m_flush = 0; pipe_adv = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
  endtask

  // Advance one clock, then settle inputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
    clr();
    m_memread = 1; m_addr = a; m_size = sz; m_load_sign = sgn;
  endtask

  initial begin
    clr();
    rst = 1;
    tick(); tick();
    rst = 0;
    #2;
    chk("reset_req", {31'h0, data_req}, 32'h0);
    chk("reset_stall", {31'h0, mem_stall}, 32'h0);
    chk("reset_load_data", load_data, 32'h0);
    tick();

    // lw 0x1000, both handshakes in the request cycle
    load(32'h1000, 2'b10, 1'b0);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hDEADBEEF; pipe_adv = 1;
    #2;
    chk("lw_req", {31'h0, data_req}, 32'h1);
    chk("lw_stall", {31'h0, mem_stall}, 32'h0);
    chk("lw_data", load_data, 32'hDEADBEEF);
    chk("lw_size", {30'h0, data_size}, 32'h2);
    tick();
    clr(); #2;
    chk("lw_req_gone", {31'h0, data_req}, 32'h0);
    chk("lw_held", load_data, 32'hDEADBEEF);
    tick();

    // lb 0x1003 sign-extended
    load(32'h1003, 2'b00, 1'b1);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h80FF0000; pipe_adv = 1;
    #2;
    chk("lb_data", load_data, 32'hFFFFFF80);
    tick();
    clr(); #2;
    chk("lb_held", load_data, 32'hFFFFFF80);
    tick();

    // lhu 0x1002 zero-extended
    load(32'h1002, 2'b01, 1'b0);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hBEEF1234; pipe_adv = 1;
    #2;
    chk("lhu_data", load_data, 32'h0000BEEF);
    tick();

    // sb 0x2001 with addr_ok delayed three cycles
    clr();
    m_memwrite = 1; m_size = 2'b00; m_addr = 32'h2001; m_wdata = 32'h12345678;
    #2;
    chk("sb_req0", {31'h0, data_req}, 32'h1);
    chk("sb_wr0", {31'h0, data_wr}, 32'h1);
    chk("sb_wdata0", data_wdata, 32'h78787878);
    chk("sb_size0", {30'h0, data_size}, 32'h0);
    chk("sb_stall0", {31'h0, mem_stall}, 32'h1);
    for (int i = 1; i < 3; i++) begin
      tick();
      m_wdata = 32'hAAAAAAAA;
      #2;
      chk("sb_req_hold", {31'h0, data_req}, 32'h1);
      chk("sb_wdata_hold", data_wdata, 32'h78787878);
      chk("sb_addr_hold", data_addr, 32'h2001);
      chk("sb_stall_hold", {31'h0, mem_stall}, 32'h1);
    end
    tick();
    data_addr_ok = 1; #2;
    chk("sb_req3", {31'h0, data_req}, 32'h1);
    chk("sb_wdata3", data_wdata, 32'h78787878);
    chk("sb_stall3", {31'h0, mem_stall}, 32'h1);
    tick();
    data_addr_ok = 0; data_data_ok = 1; pipe_adv = 1; #2;
    chk("sb_resp_req", {31'h0, data_req}, 32'h0);
    chk("sb_resp_stall", {31'h0, mem_stall}, 32'h0);
    chk("sb_no_load", load_data, 32'h0000BEEF);
    tick();

    // Misaligned accesses
    load(32'h1002, 2'b10, 1'b0); #2;
    chk("lw_mis_adel", {31'h0, adel}, 32'h1);
    chk("lw_mis_ades", {31'h0, ades}, 32'h0);
    chk("lw_mis_badva", badvaddr, 32'h1002);
    chk("lw_mis_req", {31'h0, data_req}, 32'h0);
    chk("lw_mis_stall", {31'h0, mem_stall}, 32'h0);
    tick();
    clr(); m_memwrite = 1; m_size = 2'b01; m_addr = 32'h1001; #2;
    chk("sh_mis_ades", {31'h0, ades}, 32'h1);
    chk("sh_mis_adel", {31'h0, adel}, 32'h0);
    chk("sh_mis_req", {31'h0, data_req}, 32'h0);
    tick();
    load(32'h7002, 2'b11, 1'b0); #2;
    chk("rsv_size_adel", {31'h0, adel}, 32'h1);
    tick();

    // Flush in IDLE suppresses the request
    load(32'h6000, 2'b10, 1'b0); m_flush = 1; #2;
    chk("flush_idle_req", {31'h0, data_req}, 32'h0);
    chk("flush_idle_stall", {31'h0, mem_stall}, 32'h0);
    tick();

    // Flush while in RESP: data dropped two cycles later
    load(32'h3000, 2'b10, 1'b0); data_addr_ok = 1; #2;
    chk("fr_req", {31'h0, data_req}, 32'h1);
    chk("fr_stall0", {31'h0, mem_stall}, 32'h1);
    tick();
    clr(); m_flush = 1; #2;
    chk("fr_stall1", {31'h0, mem_stall}, 32'h1);
    tick();
    clr(); #2;
    chk("fr_stall2", {31'h0, mem_stall}, 32'h1);
    tick();
    data_data_ok = 1; data_rdata = 32'h11111111; #2;
    chk("fr_stall_done", {31'h0, mem_stall}, 32'h0);
    chk("fr_dropped", load_data, 32'h0000BEEF);
    tick();
    clr(); data_data_ok = 1; data_rdata = 32'h22222222; #2;
    chk("stray_ok_ignored", load_data, 32'h0000BEEF);
    chk("fr_idle_req", {31'h0, data_req}, 32'h0);
    tick();
    load(32'h4000, 2'b10, 1'b0);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h00000042; pipe_adv = 1; #2;
    chk("post_flush_req", {31'h0, data_req}, 32'h1);
    chk("post_flush_data", load_data, 32'h00000042);
    tick();

    // Reset while in RESP, then a stray data_ok
    load(32'h5000, 2'b10, 1'b0); data_addr_ok = 1; #2;
    chk("rr_stall", {31'h0, mem_stall}, 32'h1);
    tick();
    clr(); rst = 1;
    tick();
    rst = 0; data_data_ok = 1; data_rdata = 32'hFFFFFFFF; #2;
    chk("rr_req", {31'h0, data_req}, 32'h0);
    chk("rr_stall_after", {31'h0, mem_stall}, 32'h0);
    chk("rr_load_data", load_data, 32'h0);
    chk("rr_wr", {31'h0, data_wr}, 32'h0);
    tick();
    clr(); #2;
    chk("rr_held", load_data, 32'h0);
    chk("rr_idle_req", {31'h0, data_req}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
